// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the SRAM-to-AXI bridge.
//   - FSM state encodings (legacy localparams plus an enum built on them)
//   - AXI transaction ids for the instruction and data sides
//   - fixed single-beat burst attributes
//   - wenToSize(): byte-strobe pattern to AXI transfer size
package sram_axi_bridge_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR   = 3'd1;
  localparam logic [2:0] ST_R    = 3'd2;
  localparam logic [2:0] ST_AW_W = 3'd3;
  localparam logic [2:0] ST_B    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_AR   = ST_AR,
    S_R    = ST_R,
    S_AW_W = ST_AW_W,
    S_B    = ST_B
  } busStateE;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Single byte -> 0, aligned halfword -> 1, anything else is sent as a word.
  function automatic logic [2:0] wenToSize(input logic [3:0] wen);
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 3'd0;
      4'b0011, 4'b1100:                   return 3'd1;
      default:                            return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// SRAM-style CPU fetch/load/store ports to a single-outstanding AXI3 master.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   inst_en/inst_addr        fetch request; inst_rdata result, i_stall busy
//   data_en/data_wen/...     load/store request; data_rdata result, d_stall busy
//   longest_stall            CPU frozen: completed results and done flags hold
//   ar*/r*/aw*/w*/b*         AXI3 master channels, single-beat transfers only
//
// state  | meaning
// IDLE   | no transaction; picks data request first, then fetch
// AR     | read address valid, waiting for arready
// R      | rready high, waiting for the single read beat
// AW_W   | store address and data offered, each dropped after its handshake
// B      | bready high, waiting for the write response
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        i_stall,

  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        d_stall,

  input  logic        longest_stall,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,

  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  busStateE    state;
  logic        instDone;
  logic        dataDone;
  logic [31:0] instRdataQ;
  logic [31:0] dataRdataQ;
  logic [3:0]  reqId;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [3:0]  reqWstrb;
  logic        awDone;
  logic        wDone;

  logic instPend;
  logic dataPend;
  logic awFire;
  logic wFire;
  logic instComplete;
  logic dataComplete;

  // Single-beat, one-at-a-time: ids and error responses carry no information.
  logic unusedSinks;
  assign unusedSinks = ^{rid, rresp, rlast, bid, bresp};

  assign instPend = inst_en & ~instDone;
  assign dataPend = data_en & ~dataDone;

  assign awFire = awvalid & awready;
  assign wFire  = wvalid & wready;

  assign instComplete = (state == S_R) & rvalid & (reqId == ID_INST);
  assign dataComplete = ((state == S_R) & rvalid & (reqId == ID_DATA)) |
                        ((state == S_B) & bvalid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      instDone   <= 1'b0;
      dataDone   <= 1'b0;
      instRdataQ <= '0;
      dataRdataQ <= '0;
      reqId      <= '0;
      reqAddr    <= '0;
      reqWdata   <= '0;
      reqWstrb   <= '0;
      awDone     <= 1'b0;
      wDone      <= 1'b0;
    end else begin
      // A fresh completion always raises the flag; an old one is released on
      // the first edge the pipeline is allowed to move.
      instDone <= instComplete | (instDone & longest_stall);
      dataDone <= dataComplete | (dataDone & longest_stall);
      if (instComplete) instRdataQ <= rdata;
      if ((state == S_R) && rvalid && (reqId == ID_DATA)) dataRdataQ <= rdata;

      case (state)
        S_IDLE: begin
          if (dataPend) begin
            reqId    <= ID_DATA;
            reqAddr  <= data_addr;
            reqWdata <= data_wdata;
            reqWstrb <= data_wen;
            awDone   <= 1'b0;
            wDone    <= 1'b0;
            state    <= (data_wen == 4'b0000) ? S_AR : S_AW_W;
          end else if (instPend) begin
            reqId    <= ID_INST;
            reqAddr  <= inst_addr;
            reqWstrb <= 4'b0000;
            state    <= S_AR;
          end
        end
        S_AR: begin
          if (arready) state <= S_R;
        end
        S_R: begin
          if (rvalid) state <= S_IDLE;
        end
        S_AW_W: begin
          if (awFire) awDone <= 1'b1;
          if (wFire)  wDone  <= 1'b1;
          if ((awDone | awFire) && (wDone | wFire)) state <= S_B;
        end
        S_B: begin
          if (bvalid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign i_stall    = instPend;
  assign d_stall    = dataPend;
  assign inst_rdata = instRdataQ;
  assign data_rdata = dataRdataQ;

  assign arid    = reqId;
  assign araddr  = reqAddr;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign arvalid = (state == S_AR);
  assign rready  = (state == S_R);

  assign awid    = reqId;
  assign awaddr  = reqAddr;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = wenToSize(reqWstrb);
  assign awburst = AXI_BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign awvalid = (state == S_AW_W) & ~awDone;

  assign wid     = reqId;
  assign wdata   = reqWdata;
  assign wstrb   = reqWstrb;
  assign wlast   = 1'b1;
  assign wvalid  = (state == S_AW_W) & ~wDone;

  assign bready  = (state == S_B);

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Self-checking bench for sram_axi_bridge: a delay-programmable AXI slave, a
// transaction-level model of the CPU-visible behaviour, a per-cycle compare,
// and directed scenarios with hand-computed literal expectations.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        i_stall;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        d_stall;
  logic        longest_stall;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .i_stall(i_stall),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .d_stall(d_stall), .longest_stall(longest_stall),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    case (a)
      32'hBFC00000: return 32'h3C080001;
      32'hBFC00008: return 32'h27BDFFF0;
      32'h80001000: return 32'h12345678;
      default:      return a ^ 32'hA5A50000;
    endcase
  endfunction

  // Transfer size follows from how many byte lanes are written.
  function automatic logic [2:0] sizeOf(input logic [3:0] s);
    if ($countones(s) == 1) return 3'd0;
    if ($countones(s) == 2) return 3'd1;
    return 3'd2;
  endfunction

  // Slave configuration and bookkeeping.
  int arDelay = 0, rDelay = 0, awDelay = 0, wDelay = 0, bDelay = 0;
  int arCnt = 0, rCnt = 0, awCnt = 0, wCnt = 0, bCnt = 0;
  logic sRPend = 0, sAwDone = 0, sWDone = 0, sBPend = 0;
  logic [31:0] sRData = '0;

  // Observed handshakes (evaluated just before the edge they complete on).
  logic capArFire, capRFire, capAwFire, capWFire, capBFire, capLongest, capRst;
  logic [31:0] capRdata, capAraddr, capAwaddr, capWdata;
  logic [3:0]  capArid, capWstrb;
  logic [2:0]  capAwsize;

  typedef struct packed { logic [3:0] id; logic [31:0] addr; } arEntT;
  typedef struct packed { logic [31:0] addr; logic [2:0] size; } awEntT;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; } wEntT;
  arEntT arLog[$];
  awEntT awLog[$];
  wEntT  wLog[$];
  int bCount = 0;
  int lastBCyc = -1;

  // Model: CPU-visible done/result state and the one outstanding transaction.
  logic        instDoneM = 0, dataDoneM = 0;
  logic [31:0] instResM = '0, dataResM = '0;
  logic        txnActive = 0, txnRead = 0;
  logic [3:0]  txnId = '0, txnWstrb = '0;
  logic [31:0] txnAddr = '0, txnWdata = '0;
  logic        arFiredM = 0, awFiredM = 0, wFiredM = 0;
  logic        issueNext = 0, nxtRead = 0;
  logic [3:0]  nxtId = '0, nxtWstrb = '0;
  logic [31:0] nxtAddr = '0, nxtWdata = '0;

  task automatic endOfCycle();
    if (rst) begin
      arready = 0; rvalid = 0; rdata = '0; awready = 0; wready = 0; bvalid = 0;
      arCnt = 0; rCnt = 0; awCnt = 0; wCnt = 0; bCnt = 0;
      sRPend = 0; sAwDone = 0; sWDone = 0; sBPend = 0;
    end else begin
      arready = arvalid && (arCnt >= arDelay);
      rvalid  = sRPend && (rCnt >= rDelay);
      rdata   = rvalid ? sRData : 32'hDEADBEEF;
      awready = awvalid && (awCnt >= awDelay);
      wready  = wvalid && (wCnt >= wDelay);
      bvalid  = sBPend && (bCnt >= bDelay);
    end
    capArFire = arvalid && arready;
    capRFire  = rvalid && rready;
    capAwFire = awvalid && awready;
    capWFire  = wvalid && wready;
    capBFire  = bvalid && bready;
    capRdata = rdata; capArid = arid; capAraddr = araddr;
    capAwaddr = awaddr; capAwsize = awsize; capWdata = wdata; capWstrb = wstrb;
    capLongest = longest_stall;
    capRst = rst;
    if (!rst) begin
      if (capArFire) begin arCnt = 0; sRPend = 1; sRData = memRead(araddr); rCnt = 0; end
      else if (arvalid) arCnt++;
      if (capRFire) sRPend = 0;
      else if (sRPend) rCnt++;
      if (capAwFire) begin awCnt = 0; sAwDone = 1; end
      else if (awvalid) awCnt++;
      if (capWFire) begin wCnt = 0; sWDone = 1; end
      else if (wvalid) wCnt++;
      if (capBFire) begin sBPend = 0; sAwDone = 0; sWDone = 0; end
      else if (sBPend) bCnt++;
      else if (sAwDone && sWDone) begin sBPend = 1; bCnt = 0; end
    end
    // With nothing outstanding, data beats fetch and the bus is taken next edge.
    issueNext = 0;
    if (!rst && !txnActive) begin
      if (data_en && !dataDoneM) begin
        issueNext = 1; nxtId = 4'd1; nxtAddr = data_addr; nxtRead = (data_wen == 4'b0000);
        nxtWdata = data_wdata; nxtWstrb = data_wen;
      end else if (inst_en && !instDoneM) begin
        issueNext = 1; nxtId = 4'd0; nxtAddr = inst_addr; nxtRead = 1;
        nxtWdata = '0; nxtWstrb = '0;
      end
    end
  endtask

  task automatic modelUpdate();
    logic setI, setD;
    setI = 0; setD = 0;
    if (capRst) begin
      instDoneM = 0; dataDoneM = 0; instResM = '0; dataResM = '0;
      txnActive = 0; arFiredM = 0; awFiredM = 0; wFiredM = 0;
      return;
    end
    if (capArFire) arLog.push_back('{capArid, capAraddr});
    if (capAwFire) awLog.push_back('{capAwaddr, capAwsize});
    if (capWFire)  wLog.push_back('{capWdata, capWstrb});
    if (capBFire) begin bCount++; lastBCyc = cyc; end
    if (txnActive) begin
      if (capArFire) arFiredM = 1;
      if (capAwFire) awFiredM = 1;
      if (capWFire)  wFiredM = 1;
      if (capRFire) begin
        if (txnId == 4'd0) begin instResM = capRdata; setI = 1; end
        else begin dataResM = capRdata; setD = 1; end
        txnActive = 0;
      end
      if (capBFire) begin setD = 1; txnActive = 0; end
    end
    instDoneM = setI || (instDoneM && capLongest);
    dataDoneM = setD || (dataDoneM && capLongest);
    if (issueNext) begin
      txnActive = 1; txnId = nxtId; txnAddr = nxtAddr; txnRead = nxtRead;
      txnWdata = nxtWdata; txnWstrb = nxtWstrb;
      arFiredM = 0; awFiredM = 0; wFiredM = 0;
    end
  endtask

  task automatic compare();
    logic [4:0] expCh;
    check("constOutputs",
          {arlen, awlen, arsize, arburst, awburst, arlock, awlock, arcache, awcache, arprot, awprot, wlast},
          {4'd0, 4'd0, 3'd2, 2'b01, 2'b01, 2'd0, 2'd0, 4'd0, 4'd0, 3'd0, 3'd0, 1'b1});
    check("iStall", i_stall, inst_en && !instDoneM);
    check("dStall", d_stall, data_en && !dataDoneM);
    check("instRdata", inst_rdata, instResM);
    check("dataRdata", data_rdata, dataResM);
    expCh = '0;
    if (txnActive) begin
      if (txnRead) expCh = {!arFiredM, arFiredM, 3'b000};
      else         expCh = {2'b00, !awFiredM, !wFiredM, awFiredM && wFiredM};
    end
    check("channelValidReady", {arvalid, rready, awvalid, wvalid, bready}, expCh);
    if (txnActive && txnRead && !arFiredM)
      check("arAttr", {arid, araddr}, {txnId, txnAddr});
    if (txnActive && !txnRead && !awFiredM)
      check("awAttr", {awid, awaddr, awsize}, {4'd1, txnAddr, sizeOf(txnWstrb)});
    if (txnActive && !txnRead && !wFiredM)
      check("wAttr", {wid, wstrb, wdata}, {4'd1, txnWstrb, txnWdata});
  endtask

  task automatic step();
    endOfCycle();
    @(negedge clk);
    cyc++;
    modelUpdate();
    compare();
  endtask

  typedef struct packed {
    logic [3:0] wen; logic [31:0] addr; logic [31:0] wd; int awD; int wD; logic [2:0] size;
  } storeT;
  storeT stores[3];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, startCyc, iLow, dLow, a0, b0;
    rst = 1; inst_en = 0; inst_addr = '0; data_en = 0; data_wen = '0; data_addr = '0;
    data_wdata = '0; longest_stall = 0;
    arready = 0; rvalid = 0; rdata = '0; awready = 0; wready = 0; bvalid = 0;
    rid = '0; rresp = '0; rlast = 1; bid = '0; bresp = '0;

    repeat (3) step();
    check("resetValidReady", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    check("resetResults", {inst_rdata, data_rdata}, 64'h0);
    rst = 0;
    step();

    // Zero-wait fetch: stall drops three cycles after the request.
    arLog.delete();
    inst_addr = 32'hBFC00000; inst_en = 1; startCyc = cyc; n = 0;
    do begin step(); n++; end while (i_stall && n < 20);
    check("fetchLatency", cyc - startCyc, 3);
    check("fetchArid", (arLog.size() == 1) ? arLog[0].id : 4'hF, 4'd0);
    check("fetchRdata", inst_rdata, 32'h3C080001);
    inst_en = 0;
    repeat (2) step();

    // Simultaneous fetch and load: data side first.
    arLog.delete();
    inst_addr = 32'hBFC00004; inst_en = 1;
    data_addr = 32'h80001000; data_wen = 4'b0000; data_en = 1;
    iLow = -1; dLow = -1; n = 0;
    while ((inst_en || data_en) && n < 40) begin
      step(); n++;
      if (data_en && !d_stall) begin dLow = n; data_en = 0; end
      if (inst_en && !i_stall) begin iLow = n; inst_en = 0; end
    end
    check("arbArCount", arLog.size(), 2);
    if (arLog.size() == 2) begin
      check("arbFirstAr", {arLog[0].id, arLog[0].addr}, {4'd1, 32'h80001000});
      check("arbSecondAr", {arLog[1].id, arLog[1].addr}, {4'd0, 32'hBFC00004});
    end
    check("arbDataFirst", dLow == 3, 1);
    check("arbInstLowCycle", iLow, 6);
    check("arbLoadData", data_rdata, 32'h12345678);
    step();

    // Stores with different strobes and AW/W handshake orders.
    stores[0] = '{4'b0100, 32'h80000002, 32'h00AB0000, 0, 2, 3'd0};
    stores[1] = '{4'b1111, 32'h80000010, 32'hCAFEF00D, 3, 0, 3'd2};
    stores[2] = '{4'b0011, 32'h80000020, 32'h0000BEEF, 0, 0, 3'd1};
    for (int k = 0; k < 3; k++) begin
      awLog.delete(); wLog.delete(); b0 = bCount;
      awDelay = stores[k].awD; wDelay = stores[k].wD;
      data_wen = stores[k].wen; data_addr = stores[k].addr; data_wdata = stores[k].wd;
      data_en = 1; n = 0;
      do begin step(); n++; end while (d_stall && n < 30);
      check("storeDone", d_stall, 0);
      data_en = 0;
      check("storeBCount", bCount - b0, 1);
      check("storeStallAfterB", cyc - lastBCyc, 0);
      check("storeAwCount", awLog.size(), 1);
      if (awLog.size() == 1)
        check("storeAw", {awLog[0].addr, awLog[0].size}, {stores[k].addr, stores[k].size});
      check("storeWCount", wLog.size(), 1);
      if (wLog.size() == 1)
        check("storeW", {wLog[0].strb, wLog[0].data}, {stores[k].wen, stores[k].wd});
      step();
    end
    awDelay = 0; wDelay = 0; data_wen = '0;

    // Frozen pipeline holds the completed fetch and issues nothing new.
    inst_addr = 32'hBFC00008; inst_en = 1; n = 0;
    do begin step(); n++; end while (i_stall && n < 20);
    check("frozenFetchDone", i_stall, 0);
    longest_stall = 1; a0 = arLog.size();
    repeat (5) begin
      step();
      check("frozenNoAr", arvalid, 0);
      check("frozenHold", inst_rdata, 32'h27BDFFF0);
    end
    check("frozenArCount", arLog.size() - a0, 0);
    longest_stall = 0; inst_addr = 32'hBFC0000C; n = 0;
    do begin step(); n++; end while (arLog.size() == a0 && n < 10);
    check("frozenReissue", (arLog.size() == a0 + 1) ? arLog[a0].addr : 32'h0, 32'hBFC0000C);
    n = 0;
    while (i_stall && n < 20) begin step(); n++; end
    check("frozenNextDone", i_stall, 0);
    inst_en = 0;
    step();

    // Reset while waiting for the read beat.
    rDelay = 3; inst_addr = 32'hBFC00010; inst_en = 1; n = 0;
    do begin step(); n++; end while (!rready && n < 10);
    check("abortInR", rready, 1);
    step();
    rst = 1;
    step();
    check("abortReady", {rready, arvalid}, 2'b00);
    check("abortIStall", i_stall, 1);
    check("abortResult", inst_rdata, 32'h0);
    rst = 0; rDelay = 0; n = 0;
    do begin step(); n++; end while (i_stall && n < 20);
    check("abortRefetch", inst_rdata, 32'h1A650010);
    inst_en = 0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 Parameters: none; AXI constants live in the shared package.
REQ-002 clk  in  1  sole clock, all logic on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 inst_en  in  1  CPU fetch request.
REQ-005 inst_addr  in  32  fetch address, word-aligned.
REQ-006 inst_rdata  out  32  fetched word, held after completion.
REQ-007 i_stall  out  1  fetch pending, not yet complete.
REQ-008 data_en  in  1  CPU load/store request.
REQ-009 data_wen  in  4  byte write strobes; 0000 means load.
REQ-010 data_addr  in  32  load/store address.
REQ-011 data_wdata  in  32  store data, lane-aligned.
REQ-012 data_rdata  out  32  loaded word, held after completion.
REQ-013 d_stall  out  1  data access pending, not yet complete.
REQ-014 longest_stall  in  1  CPU pipeline frozen; completed results must be held.
REQ-015 AXI master: arid[3:0] araddr[31:0] arvalid arready(in); rid[3:0](in) rdata[31:0](in) rresp[1:0](in) rlast(in) rvalid(in) rready; awid[3:0] awaddr[31:0] awsize[2:0] awvalid awready(in); wid[3:0] wdata[31:0] wstrb[3:0] wlast wvalid wready(in); bid[3:0](in) bresp[1:0](in) bvalid(in) bready.
REQ-016 Constant outputs: arlen = awlen = 0, arsize = 2, arburst = awburst = INCR (01), lock/cache/prot = 0, wlast = 1.

Function
REQ-017 FSM states: IDLE, AR, R, AW_W, B; one transaction outstanding at most.
REQ-018 IDLE: pending data request (data_en & ~data_done) wins over pending inst request (inst_en & ~inst_done).
REQ-019 Any read (inst, or data with data_wen = 0) goes IDLE->AR; the latched address and id are used (inst 0, data 1).
REQ-020 AR: arvalid = 1; on arvalid & arready go to R.
REQ-021 R: rready = 1; on rvalid, capture rdata into the selected result register, set that done flag, go to IDLE.
REQ-022 A store (data_wen != 0) goes IDLE->AW_W: awvalid and wvalid both 1; each drops individually after its own handshake; go to B once both have completed (same cycle or either order).
REQ-023 awsize from wen: 0001/0010/0100/1000 -> 0; 0011/1100 -> 1; 1111 -> 2; wstrb = wen; awaddr = data_addr.
REQ-024 B: bready = 1; on bvalid set data_done and go to IDLE; bresp and rresp are ignored.
REQ-025 Address, id, wdata and wstrb are latched on leaving IDLE and stay stable until the handshake completes.
REQ-026 i_stall = inst_en & ~inst_done and d_stall = data_en & ~data_done, both combinational.
REQ-027 A done flag falls to 0 on the first clk where longest_stall = 0; while longest_stall = 1 the flags and result registers hold, and a done request is never reissued.
REQ-028 Minimum read latency: request to i_stall/d_stall low = 3 cycles (IDLE, AR, R), assuming the slave responds with zero wait.
REQ-029 A fetch arriving while a data transaction is in progress waits and is served next from IDLE.

Reset
REQ-030 On rst: state = IDLE, all valid/ready outputs = 0, done flags = 0, result registers = 0.
REQ-031 rst asserted mid-transaction aborts it immediately; rst is applied system-wide, so the slave is reset with the bridge.

Structure
REQ-032 The shared package holds the FSM state enum, ID_INST = 0, ID_DATA = 1, the fixed len/size/burst constants and the wen->awsize function.
REQ-033 The block is a single module with no sub-module.

Verification
REQ-034 Fetch 0xBFC00000, arready immediate, rvalid 1 cycle later with 0x3C080001 -> arid = 0, inst_rdata = 0x3C080001, i_stall low in cycle 3.
REQ-035 inst_en and a load from 0x80001000 asserted together -> first AR has arid = 1 at 0x80001000, then arid = 0; d_stall falls before i_stall.
REQ-036 Store wen = 0100 to 0x80000002 with 0x00AB0000, awready 2 cycles before wready -> awsize = 0, wstrb = 0100, one B handshake, d_stall low after bvalid.
REQ-037 longest_stall = 1 for 5 cycles after a fetch completes -> no new AR, inst_rdata stable; longest_stall = 0 -> the next fetch is issued.
REQ-038 rst asserted while in R -> next cycle state = IDLE, rready = 0, i_stall = inst_en.
